// File: rtl/pic_command_sequencer.sv
// Command sequencer for an 8259-style PIC: decodes ICW1..ICW4 and OCW1..OCW3 writes,
// and generates the strobes for the INTA pulse sequence.
module pic_command_sequencer #(
  parameter logic [7:0] IMR_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       inta_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] icw1,
  output logic [7:0] icw2,
  output logic [7:0] icw3,
  output logic [7:0] icw4,
  output logic [7:0] imr,
  output logic       init_done,
  output logic       f_p,
  output logic       s_p,
  output logic       ns_eoi,
  output logic       sp_eoi,
  output logic [2:0] eoi_level,
  output logic       aeoi_p,
  output logic       rot_aeoi,
  output logic       read_isr
);

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  state_t     state;
  logic       wr_prev;
  logic       inta_prev;
  logic [1:0] inta_cnt;
  logic       wr_edge;
  logic       inta_edge;
  logic       is_icw1;
  logic       inta_last;
  logic       unused_rd;

  // rd_n only steers the external read mux; it never touches sequencer state.
  assign unused_rd = rd_n;

  assign wr_edge   = !cs_n && !wr_n && wr_prev;
  assign inta_edge = !inta_n && inta_prev;
  assign is_icw1   = wr_edge && !a0 && din[4];
  assign inta_last = (inta_cnt == (icw4[0] ? 2'd1 : 2'd2));
  assign init_done = (state == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_ICW1;
      wr_prev   <= 1'b1;
      inta_prev <= 1'b1;
      inta_cnt  <= 2'd0;
      icw1      <= 8'h00;
      icw2      <= 8'h00;
      icw3      <= 8'h00;
      icw4      <= 8'h00;
      imr       <= IMR_INIT;
      f_p       <= 1'b0;
      s_p       <= 1'b0;
      ns_eoi    <= 1'b0;
      sp_eoi    <= 1'b0;
      eoi_level <= 3'd0;
      aeoi_p    <= 1'b0;
      rot_aeoi  <= 1'b0;
      read_isr  <= 1'b0;
    end else begin
      wr_prev   <= wr_n;
      inta_prev <= inta_n;
      f_p       <= 1'b0;
      s_p       <= 1'b0;
      ns_eoi    <= 1'b0;
      sp_eoi    <= 1'b0;
      aeoi_p    <= 1'b0;

      // ICW1 restarts initialisation from any state and swallows a coincident INTA edge.
      if (is_icw1) begin
        icw1     <= din;
        imr      <= IMR_INIT;
        read_isr <= 1'b0;
        rot_aeoi <= 1'b0;
        inta_cnt <= 2'd0;
        if (!din[0]) icw4 <= 8'h00;
        state    <= WAIT_ICW2;
      end else begin
        if (wr_edge && a0) begin
          case (state)
            WAIT_ICW2: begin
              icw2 <= din;
              if (!icw1[1])     state <= WAIT_ICW3;
              else if (icw1[0]) state <= WAIT_ICW4;
              else              state <= READY;
            end
            WAIT_ICW3: begin
              icw3  <= din;
              state <= icw1[0] ? WAIT_ICW4 : READY;
            end
            WAIT_ICW4: begin
              icw4  <= din;
              state <= READY;
            end
            READY:   imr <= din;
            default: ;
          endcase
        end else if (wr_edge && state == READY) begin
          if (din[4:3] == 2'b00) begin
            case (din[7:5])
              3'b001, 3'b101: ns_eoi <= 1'b1;
              3'b011, 3'b111: begin
                sp_eoi    <= 1'b1;
                eoi_level <= din[2:0];
              end
              3'b100:  rot_aeoi <= 1'b1;
              3'b000:  rot_aeoi <= 1'b0;
              default: ;
            endcase
          end else if (din[4:3] == 2'b01 && din[1]) begin
            read_isr <= din[0];
          end
        end

        if (inta_edge && state == READY) begin
          if (inta_last) begin
            s_p      <= 1'b1;
            aeoi_p   <= icw4[1];
            inta_cnt <= 2'd0;
          end else begin
            f_p      <= (inta_cnt == 2'd0);
            inta_cnt <= inta_cnt + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Bench for pic_command_sequencer: directed init/OCW/INTA scenarios plus random bus
// traffic, all compared against a word-queue reference model every cycle.
module tb_pic_command_sequencer;

  localparam logic [7:0] IMR_INIT = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, inta_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] icw1, icw2, icw3, icw4, imr;
  logic       init_done, f_p, s_p, ns_eoi, sp_eoi, aeoi_p, rot_aeoi, read_isr;
  logic [2:0] eoi_level;

  int n_checks = 0;
  int n_fail = 0;

  pic_command_sequencer #(.IMR_INIT(IMR_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .inta_n(inta_n),
    .a0(a0), .din(din), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .imr(imr),
    .init_done(init_done), .f_p(f_p), .s_p(s_p), .ns_eoi(ns_eoi), .sp_eoi(sp_eoi),
    .eoi_level(eoi_level), .aeoi_p(aeoi_p), .rot_aeoi(rot_aeoi), .read_isr(read_isr)
  );

  always #5 clk = ~clk;

  // Reference model: the outstanding init words are held as a queue of word numbers.
  logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_imr;
  logic [2:0] m_level;
  bit         m_f, m_s, m_ns, m_sp, m_aeoi, m_rot, m_isr;
  bit         m_armed, m_wr_prev, m_inta_prev;
  int         m_pending[$];
  int         m_pulses;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_armed && (m_pending.size() == 0);
  endfunction

  task automatic model_reset();
    m_icw1 = 0; m_icw2 = 0; m_icw3 = 0; m_icw4 = 0; m_imr = IMR_INIT; m_level = 0;
    m_f = 0; m_s = 0; m_ns = 0; m_sp = 0; m_aeoi = 0; m_rot = 0; m_isr = 0;
    m_armed = 0; m_wr_prev = 1; m_inta_prev = 1; m_pulses = 0;
    m_pending.delete();
  endtask

  task automatic model_step();
    bit we, ie, rdy;
    int len;
    we  = !cs_n && !wr_n && m_wr_prev;
    ie  = !inta_n && m_inta_prev;
    rdy = m_ready();
    m_f = 0; m_s = 0; m_ns = 0; m_sp = 0; m_aeoi = 0;
    if (we && !a0 && din[4]) begin
      m_icw1 = din; m_imr = IMR_INIT; m_isr = 0; m_rot = 0; m_pulses = 0;
      if (!din[0]) m_icw4 = 8'h00;
      m_pending.delete();
      m_pending.push_back(2);
      if (!din[1]) m_pending.push_back(3);
      if (din[0]) m_pending.push_back(4);
      m_armed = 1;
    end else begin
      if (we) begin
        if (m_armed && m_pending.size() > 0) begin
          if (a0) begin
            if (m_pending[0] == 2) m_icw2 = din;
            else if (m_pending[0] == 3) m_icw3 = din;
            else m_icw4 = din;
            m_pending.delete(0);
          end
        end else if (rdy) begin
          if (a0) m_imr = din;
          else if (din[4:3] == 2'b00) begin
            if (din[5]) begin
              if (din[6]) begin m_sp = 1; m_level = din[2:0]; end
              else m_ns = 1;
            end else if (din[7:5] == 3'b100) m_rot = 1;
            else if (din[7:5] == 3'b000) m_rot = 0;
          end else if (din[4:3] == 2'b01 && din[1]) m_isr = din[0];
        end
      end
      if (ie && rdy) begin
        m_pulses++;
        len = m_icw4[0] ? 2 : 3;
        if (m_pulses == len) begin
          m_s = 1; m_aeoi = m_icw4[1]; m_pulses = 0;
        end else if (m_pulses == 1) m_f = 1;
      end
    end
    m_wr_prev = wr_n;
    m_inta_prev = inta_n;
  endtask

  task automatic compare_all();
    check("icw1", icw1, m_icw1);
    check("icw2", icw2, m_icw2);
    check("icw3", icw3, m_icw3);
    check("icw4", icw4, m_icw4);
    check("imr", imr, m_imr);
    check("init_done", init_done, m_ready());
    check("f_p", f_p, m_f);
    check("s_p", s_p, m_s);
    check("ns_eoi", ns_eoi, m_ns);
    check("sp_eoi", sp_eoi, m_sp);
    check("eoi_level", eoi_level, m_level);
    check("aeoi_p", aeoi_p, m_aeoi);
    check("rot_aeoi", rot_aeoi, m_rot);
    check("read_isr", read_isr, m_isr);
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic c, input logic w, input logic r, input logic i,
                       input logic a, input logic [7:0] d);
    cs_n = c; wr_n = w; rd_n = r; inta_n = i; a0 = a; din = d;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, a, d);
    idle();
  endtask

  task automatic inta_edge_only();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs_n = 1; wr_n = 1; rd_n = 1; inta_n = 1; a0 = 0; din = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_imr", imr, IMR_INIT);
    check("rst_done", init_done, 1'b0);

    // Single, 8086 + AEOI: ICW3 skipped.
    wr(0, 8'h13); wr(1, 8'h20);
    check("r039_mid", init_done, 1'b0);
    wr(1, 8'h03);
    check("r039_done", init_done, 1'b1);
    check("r039_icw4", icw4, 8'h03);
    inta_edge_only();
    check("r041_f", f_p, 1'b1);
    idle();
    inta_edge_only();
    check("r041_s", s_p, 1'b1);
    check("r041_aeoi", aeoi_p, 1'b1);
    idle();

    // READY write sequence.
    cycle(0, 0, 1, 1, 0, 8'h63);
    check("r042_sp", sp_eoi, 1'b1);
    check("r042_lvl", eoi_level, 3'd3);
    idle();
    cycle(0, 0, 1, 1, 0, 8'h20);
    check("r042_ns", ns_eoi, 1'b1);
    idle();
    wr(0, 8'h0B);
    check("r042_isr", read_isr, 1'b1);
    wr(1, 8'hF0);
    check("r042_imr", imr, 8'hF0);

    // Cascade, 8085: three-pulse INTA sequence.
    wr(0, 8'h10); wr(1, 8'h08); wr(1, 8'h04);
    check("r040_done", init_done, 1'b1);
    check("r040_icw4", icw4, 8'h00);
    inta_edge_only(); check("r040_e1", f_p, 1'b1); idle();
    inta_edge_only(); check("r040_e2f", f_p, 1'b0); check("r040_e2s", s_p, 1'b0); idle();
    inta_edge_only(); check("r040_e3", s_p, 1'b1); check("r040_e3a", aeoi_p, 1'b0); idle();

    // Ignored write in WAIT_ICW3, then ICW1 restart.
    wr(1, 8'h3C);
    wr(0, 8'h10); wr(1, 8'h08);
    wr(0, 8'h00);
    check("r043_icw3", icw3, 8'h04);
    check("r043_done", init_done, 1'b0);
    wr(0, 8'h17);
    check("r043_imr", imr, IMR_INIT);
    wr(1, 8'h40);
    check("r043_icw4wait", init_done, 1'b0);
    wr(1, 8'h01);
    check("r043_ready", init_done, 1'b1);

    // Reset between INTA pulses.
    inta_edge_only(); check("r044_f", f_p, 1'b1); idle();
    do_reset();
    inta_edge_only(); check("r044_nos", s_p, 1'b0); idle();
    wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h03);
    inta_edge_only(); check("r044_f2", f_p, 1'b1); idle();

    // Held-low wr_n counts once: second OCW1 value must not land.
    cycle(0, 0, 1, 1, 1, 8'h11);
    cycle(0, 0, 1, 1, 1, 8'h22);
    check("held_wr", imr, 8'h11);
    idle();

    // ICW1 wins over a coincident INTA edge.
    cycle(0, 0, 1, 0, 0, 8'h13);
    check("prio_f", f_p, 1'b0);
    idle();

    for (int k = 0; k < 3000; k++) begin
      logic [7:0] d;
      int r;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 15);
        if (r == 0)      d = {3'($urandom), 1'b1, 4'($urandom)};
        else if (r < 8)  d = {3'($urandom), 2'b00, 3'($urandom)};
        else if (r < 11) d = {3'($urandom), 2'b01, 3'($urandom)};
        else             d = 8'($urandom) & 8'hEF;
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
              $urandom_range(0, 3) != 0, 1'($urandom), d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_command_sequencer.md
PIC_COMMAND_SEQUENCER -- requirements
Module: pic_command_sequencer

Interface
REQ-001 SHALL have parameter IMR_INIT, default 8'h00: the value loaded into the IMR at reset and on every ICW1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cs_n / wr_n / rd_n / inta_n, input, 1 bit each: active-low bus strobes, synchronous to clk.
REQ-005 SHALL have port a0, input, 1 bit: register address select.
REQ-006 SHALL have port din, input, 8 bits: write data.
REQ-007 SHALL have port icw1 / icw2 / icw3 / icw4, output, 8 bits each: latched init words.
REQ-008 SHALL have port imr, output, 8 bits: latched OCW1 interrupt mask.
REQ-009 SHALL have port init_done, output, 1 bit: high while the state machine is in READY.
REQ-010 SHALL have port f_p / s_p, output, 1 bit each: one-cycle strobes for the first INTA pulse and the last (vector) INTA pulse.
REQ-011 SHALL have port ns_eoi / sp_eoi, output, 1 bit each: one-cycle EOI strobes.
REQ-012 SHALL have port eoi_level, output, 3 bits: level for specific EOI.
REQ-013 SHALL have port aeoi_p, output, 1 bit: one-cycle auto-EOI strobe.
REQ-014 SHALL have port rot_aeoi, output, 1 bit: rotate-on-AEOI mode.
REQ-015 SHALL have port read_isr, output, 1 bit: read select, 0 = IRR, 1 = ISR.

Function
REQ-016 SHALL detect a write on the cycle where cs_n=0 and wr_n=0 while wr_n was 1 on the previous cycle; a held-low wr_n counts as one write.
REQ-017 SHALL detect an INTA edge on the cycle where inta_n=0 while inta_n was 1 on the previous cycle; cs_n is ignored for INTA.
REQ-018 SHALL implement init FSM states WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-019 SHALL treat any write with a0=0 and din[4]=1 as ICW1, in any state, with these actions: latch icw1; set imr=IMR_INIT; clear read_isr, rot_aeoi and the INTA count; go to WAIT_ICW2.
REQ-020 SHALL, in WAIT_ICW2 on a write with a0=1, latch icw2 and then branch:
- to WAIT_ICW3 if icw1[1]=0 (cascade);
- else to WAIT_ICW4 if icw1[0]=1;
- else to READY.
REQ-021 SHALL, in WAIT_ICW3 on a write with a0=1, latch icw3, then go to WAIT_ICW4 if icw1[0]=1, else to READY.
REQ-022 SHALL, in WAIT_ICW4 on a write with a0=1, latch icw4 and go to READY.
REQ-023 SHALL force icw4=8'h00 on ICW1 whenever icw1[0]=0.
REQ-024 SHALL ignore writes with a0=0 and din[4]=0 in WAIT_ICW2..WAIT_ICW4; state and registers are unchanged.
REQ-025 SHALL ignore all writes except ICW1 in WAIT_ICW1, the post-reset state.
REQ-026 SHALL, in READY, treat a write with a0=1 as OCW1: imr=din.
REQ-027 SHALL, in READY, decode a write with a0=0, din[4:3]=00 as OCW2 by din[7:5]:
- 001: ns_eoi pulse;
- 011: sp_eoi pulse with eoi_level=din[2:0];
- 101: ns_eoi pulse;
- 111: sp_eoi pulse with eoi_level=din[2:0];
- 100: rot_aeoi=1;
- 000: rot_aeoi=0;
- other codes: no action.
REQ-028 SHALL, in READY, treat a write with a0=0, din[4:3]=01 as OCW3: when din[1]=1, read_isr=din[0]; when din[1]=0, read_isr is unchanged.
REQ-029 SHALL count INTA edges only in READY, using a 2-bit counter.
REQ-030 SHALL set the INTA sequence length: 2 pulses when icw4[0]=1 (8086), 3 pulses when icw4[0]=0 (8085).
REQ-031 SHALL, on INTA edge 1, assert f_p for one cycle, registered (1 cycle after the edge is detected).
REQ-032 SHALL, on the final INTA edge, assert s_p for one cycle and reset the counter to 0; the middle edge in 8085 mode produces no strobe.
REQ-033 SHALL assert aeoi_p together with s_p when icw4[1]=1.
REQ-034 SHALL ignore INTA edges outside READY.
REQ-035 SHALL give ICW1 priority when a write and an INTA edge coincide; the INTA edge is discarded.
REQ-036 SHALL keep rd_n out of all state changes; rd_n is only a pass-through concern of the read mux.

Reset
REQ-037 SHALL, on rst_n=0, asynchronously force:
- FSM to WAIT_ICW1;
- icw1..icw4 = 8'h00;
- imr = IMR_INIT;
- init_done, f_p, s_p, ns_eoi, sp_eoi, aeoi_p, rot_aeoi, read_isr = 0;
- eoi_level = 0 and INTA count = 0.
REQ-038 SHALL, on reset mid-sequence (during init or between INTA pulses), discard the partial state with no strobe emitted.

Verification
REQ-039 SHALL pass: ICW1=8'h13, ICW2=8'h20, ICW4=8'h03 -> icw3 skipped, init_done=1 after the third write, icw4=8'h03.
REQ-040 SHALL pass: ICW1=8'h10, ICW2=8'h08, ICW3=8'h04 -> init_done=1 and icw4=8'h00; next INTA edges: edge1 f_p, edge2 none, edge3 s_p.
REQ-041 SHALL pass: in READY (8086 mode, AEOI), two INTA edges -> f_p, then s_p together with aeoi_p.
REQ-042 SHALL pass the READY write sequence:
- OCW2=8'h63 -> sp_eoi pulse with eoi_level=3;
- OCW2=8'h20 -> ns_eoi pulse;
- OCW3=8'h0B -> read_isr=1;
- OCW1=8'hF0 -> imr=8'hF0.
REQ-043 SHALL pass: in WAIT_ICW3, a write of 8'h00 with a0=0 -> ignored; then ICW1=8'h17 -> imr=IMR_INIT and state WAIT_ICW2.
REQ-044 SHALL pass: rst_n asserted after INTA edge 1 -> no s_p; after re-init, the next INTA edge yields f_p.
